// File: rtl/operand_collector_if.sv
// rtl/operand_collector_if.sv - decode/execute handshake bundle for operand_collector (sum port when COLLECTOR_SUM_EN)
interface operand_collector_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CTR_W = 12
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                     put_en;
  logic                     op_en;
  logic [WIDTH-1:0]         value;
  logic [CTR_W-1:0]         control_ctr;
  logic [DEPTH*WIDTH-1:0]   slot_data;
  logic [DEPTH-1:0]         slot_valid;
  logic [CW-1:0]            count;
  logic                     full;
  logic                     op_fire;
  logic [CW-1:0]            op_count;
  logic                     overflow;
  logic                     conflict;
  logic [CTR_W-1:0]         accumulator_ctr;
`ifdef COLLECTOR_SUM_EN
  logic [WIDTH+CW-1:0]      sum;
`endif

  // decode side: drives instructions, observes collected operands
  modport master (
`ifdef COLLECTOR_SUM_EN
    input  sum,
`endif
    output put_en, op_en, value, control_ctr,
    input  slot_data, slot_valid, count, full, op_fire, op_count,
    input  overflow, conflict, accumulator_ctr
  );

  // collector side
  modport slave (
`ifdef COLLECTOR_SUM_EN
    output sum,
`endif
    input  put_en, op_en, value, control_ctr,
    output slot_data, slot_valid, count, full, op_fire, op_count,
    output overflow, conflict, accumulator_ctr
  );
endinterface

// File: rtl/operand_collector.sv
// rtl/operand_collector.sv - DEPTH-slot operand collector, one event per control_ctr value (optional COLLECTOR_SUM_EN running sum)
module operand_collector #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CTR_W = 12
) (
  input logic               clk,
  input logic               rst_n,
  operand_collector_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = WIDTH + CW;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [DEPTH*WIDTH-1:0] slot_data_q;
  logic [DEPTH-1:0]       slot_valid_q;
  logic [CW-1:0]          count_q;
  logic                   op_fire_q;
  logic [CW-1:0]          op_count_q;
  logic                   overflow_q;
  logic                   conflict_q;
  logic [CTR_W-1:0]       acc_ctr_q;
  logic                   first_pending_q;
  logic [1:0]             state;
  logic                   event_ok;
`ifdef COLLECTOR_SUM_EN
  logic [SW-1:0]          sum_q;
`endif

  // occupancy state is a pure function of the fill count
  always_comb begin
    state = ST_FILLING;
    if (count_q == '0)
      state = ST_EMPTY;
    else if (count_q == DEPTH_C)
      state = ST_FULL;
  end

  // a new instruction is recognised by a change of control_ctr (or the first one after reset)
  assign event_ok = first_pending_q || (bus.control_ctr != acc_ctr_q);

  // slot fill, op consume and sticky error tracking, one action per accepted instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_data_q     <= '0;
      slot_valid_q    <= '0;
      count_q         <= '0;
      op_fire_q       <= 1'b0;
      op_count_q      <= '0;
      overflow_q      <= 1'b0;
      conflict_q      <= 1'b0;
      acc_ctr_q       <= '0;
      first_pending_q <= 1'b1;
`ifdef COLLECTOR_SUM_EN
      sum_q           <= '0;
`endif
    end else begin
      op_fire_q <= 1'b0;
      if (event_ok) begin
        acc_ctr_q       <= bus.control_ctr;
        first_pending_q <= 1'b0;
        if (bus.put_en && !bus.op_en) begin
          if (state == ST_FULL) begin
            overflow_q <= 1'b1;
          end else begin
            // slots fill in order, so the next free slot index equals the count
            for (int i = 0; i < DEPTH; i++) begin
              if (count_q == CW'(i)) begin
                slot_data_q[i*WIDTH +: WIDTH] <= bus.value;
                slot_valid_q[i]               <= 1'b1;
              end
            end
            count_q <= count_q + CW'(1);
`ifdef COLLECTOR_SUM_EN
            sum_q   <= sum_q + SW'(bus.value);
`endif
          end
        end else if (bus.op_en && !bus.put_en) begin
          // slot_data is kept so the ALU can read operands during the op_fire cycle
          op_fire_q    <= 1'b1;
          op_count_q   <= count_q;
          slot_valid_q <= '0;
          count_q      <= '0;
`ifdef COLLECTOR_SUM_EN
          sum_q        <= '0;
`endif
        end else if (bus.op_en && bus.put_en) begin
          conflict_q <= 1'b1;
        end
      end
    end
  end

  assign bus.slot_data       = slot_data_q;
  assign bus.slot_valid      = slot_valid_q;
  assign bus.count           = count_q;
  assign bus.full            = (state == ST_FULL);
  assign bus.op_fire         = op_fire_q;
  assign bus.op_count        = op_count_q;
  assign bus.overflow        = overflow_q;
  assign bus.conflict        = conflict_q;
  assign bus.accumulator_ctr = acc_ctr_q;
`ifdef COLLECTOR_SUM_EN
  assign bus.sum             = sum_q;
`endif
endmodule

// File: tb/tb_operand_collector.sv
// tb/tb_operand_collector.sv - self-checking bench for operand_collector (COLLECTOR_SUM_EN aware)
module tb_operand_collector;
  localparam int W  = 8;
  localparam int D  = 3;
  localparam int C  = 12;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;

  operand_collector_if #(.WIDTH(W), .DEPTH(D), .CTR_W(C)) bus ();
  operand_collector #(.WIDTH(W), .DEPTH(D), .CTR_W(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference model: a list of stored operands plus flags
  logic [W-1:0] m_data [D];
  int           m_n;
  bit           m_fire;
  int           m_opcount;
  bit           m_ovf;
  bit           m_conf;
  int           m_acc;
  bit           m_first;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_data[i] = '0;
    m_n = 0; m_fire = 0; m_opcount = 0; m_ovf = 0; m_conf = 0; m_acc = 0; m_first = 1;
  endtask

  task automatic model_step(input bit rst, input bit put, input bit op, input int val, input int ctr);
    if (!rst) begin
      model_reset();
      return;
    end
    m_fire = 0;
    if (m_first || ctr != m_acc) begin
      m_acc = ctr;
      m_first = 0;
      if (put && !op) begin
        if (m_n == D) m_ovf = 1;
        else begin
          m_data[m_n] = val[W-1:0];
          m_n++;
        end
      end else if (op && !put) begin
        m_fire = 1;
        m_opcount = m_n;
        m_n = 0;
      end else if (op && put) begin
        m_conf = 1;
      end
    end
  endtask

  task automatic check_all();
    logic [D*W-1:0] e_data;
    int e_sum;
    e_sum = 0;
    for (int i = 0; i < D; i++) begin
      e_data[i*W +: W] = m_data[i];
      if (i < m_n) e_sum += int'(m_data[i]);
    end
    chk("slot_data", 64'(bus.slot_data), 64'(e_data));
    chk("slot_valid", 64'(bus.slot_valid), 64'((1 << m_n) - 1));
    chk("count", 64'(bus.count), 64'(m_n));
    chk("full", 64'(bus.full), 64'(m_n == D));
    chk("op_fire", 64'(bus.op_fire), 64'(m_fire));
    chk("op_count", 64'(bus.op_count), 64'(m_opcount));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    chk("conflict", 64'(bus.conflict), 64'(m_conf));
    chk("accumulator_ctr", 64'(bus.accumulator_ctr), 64'(m_acc));
`ifdef COLLECTOR_SUM_EN
    chk("sum", 64'(bus.sum), 64'(e_sum));
`endif
  endtask

  task automatic cyc(input bit rst, input bit put, input bit op, input int val, input int ctr);
    @(negedge clk);
    rst_n           = rst;
    bus.put_en      = put;
    bus.op_en       = op;
    bus.value       = val[W-1:0];
    bus.control_ctr = ctr[C-1:0];
    @(posedge clk);
    model_step(rst, put, op, val, ctr);
    #1;
    check_all();
  endtask

  initial begin
    int ctr;
    bit put, op;
    bus.put_en = 0; bus.op_en = 0; bus.value = '0; bus.control_ctr = '0;
    model_reset();

    // reset state
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 8'h55, 7);

    // three puts fill the collector
    cyc(1, 1, 0, 8'h11, 1);
    cyc(1, 1, 0, 8'h22, 2);
    cyc(1, 1, 0, 8'h33, 3);
    chk("plan_data", 64'(bus.slot_data), 64'h332211);
    chk("plan_valid", 64'(bus.slot_valid), 64'h7);
    chk("plan_full", 64'(bus.full), 64'h1);

    // put while full, then op
    cyc(1, 1, 0, 8'h44, 4);
    chk("plan_ovf", 64'(bus.overflow), 64'h1);
    chk("plan_ovf_data", 64'(bus.slot_data), 64'h332211);
    cyc(1, 0, 1, 0, 5);
    chk("plan_fire", 64'(bus.op_fire), 64'h1);
    chk("plan_opcount", 64'(bus.op_count), 64'h3);
    chk("plan_op_data", 64'(bus.slot_data), 64'h332211);
    cyc(1, 0, 1, 0, 5);
    chk("plan_fire_pulse", 64'(bus.op_fire), 64'h0);

    // held instruction acts once
    cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(1, 1, 0, 8'h7A, 5);
    chk("plan_held_count", 64'(bus.count), 64'h1);

    // simultaneous put and op
    cyc(1, 1, 1, 8'h99, 9);
    chk("plan_conflict", 64'(bus.conflict), 64'h1);
    chk("plan_conflict_ctr", 64'(bus.accumulator_ctr), 64'h9);
    chk("plan_conflict_count", 64'(bus.count), 64'h1);

    // reset mid-fill, then ctr 0 accepted via first_pending
    cyc(1, 1, 0, 8'hA1, 10);
    cyc(0, 1, 0, 8'hA2, 11);
    cyc(1, 1, 0, 8'hB0, 0);
    chk("plan_first_pending", 64'(bus.slot_data), 64'hB0);

`ifdef COLLECTOR_SUM_EN
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 8'hFF, 1);
    cyc(1, 1, 0, 8'hFF, 2);
    cyc(1, 1, 0, 8'hFF, 3);
    chk("plan_sum", 64'(bus.sum), 64'h2FD);
    cyc(1, 0, 1, 0, 4);
    chk("plan_sum_clear", 64'(bus.sum), 64'h0);
`endif

    // randomized traffic against the model
    cyc(0, 0, 0, 0, 0);
    ctr = 0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 1) == 1) ctr = int'($urandom_range(0, (1 << C) - 1));
      put = ($urandom_range(0, 9) < 6);
      op  = ($urandom_range(0, 9) < 3);
      cyc(($urandom_range(0, 49) != 0), put, op, int'($urandom_range(0, 255)), ctr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/operand_collector.md
Name: operand_collector

Overview:
- Parametrised successor to the 3-slot, 8-bit put/op accumulator.
- Collects up to DEPTH operands of WIDTH bits, one per new instruction, for the execute stage.
- Fully synchronous with registered outputs. Adds fill count, full flag, overflow and conflict detection, and an op-fire pulse.
- Sits between decode (put_en/op_en/control_ctr) and the ALU operand muxes.

Parameters:
- WIDTH, 8, operand width in bits
- DEPTH, 3, number of operand slots (1..16)
- CTR_W, 12, width of the instruction control counter

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- put_en  in  1  store value into the next free slot
- op_en  in  1  consume operands, clear all valid bits
- value  in  WIDTH  operand to store
- control_ctr  in  CTR_W  instruction counter; one event accepted per distinct value
- slot_data  out  DEPTH*WIDTH  slot i at bits [i*WIDTH +: WIDTH]
- slot_valid  out  DEPTH  per-slot valid bits
- count  out  $clog2(DEPTH+1)  number of valid slots
- full  out  1  count == DEPTH
- op_fire  out  1  one-cycle pulse on an accepted op
- op_count  out  $clog2(DEPTH+1)  count captured at the accepted op
- overflow  out  1  sticky: a put arrived while full
- conflict  out  1  sticky: put_en and op_en both high on an accepted event
- accumulator_ctr  out  CTR_W  control_ctr of the last accepted event

Behaviour:
- Reset (rst_n low at an edge):
  - slot_data = 0, slot_valid = 0, count = 0, op_op_count = 0.
  - op_fire = 0, overflow = 0, conflict = 0, accumulator_ctr = 0.
  - first_pending = 1.
  - Reset overrides every other input on that edge and may arrive mid-fill; partial contents are discarded.
- Event acceptance:
  - An edge is an event when rst_n = 1 and (first_pending = 1 or control_ctr != accumulator_ctr).
  - On an event: accumulator_ctr <= control_ctr and first_pending <= 0.
  - Non-event edges leave all state unchanged, except that op_fire returns to 0.
  - An instruction held for many cycles therefore acts exactly once.
- Latency: outputs reflect an event on the cycle after the accepting edge (1 cycle).
- States, derived from count:
  - EMPTY (count = 0), FILLING (0 < count < DEPTH), FULL (count = DEPTH).
- Put (put_en = 1, op_en = 0):
  - EMPTY/FILLING: the lowest-index invalid slot takes value; its valid bit sets; count += 1.
  - Slots fill strictly in order 0, 1, 2, and so on.
  - FULL: value is dropped, overflow <= 1, slot contents unchanged.
- Op (op_en = 1, put_en = 0):
  - op_fire <= 1 for exactly one cycle; op_count <= current count.
  - slot_valid <= 0, count <= 0.
  - slot_data is retained, so the ALU reads operands in the op_fire cycle.
  - An op in EMPTY is legal: op_fire pulses with op_count = 0.
- Both put_en and op_en high: no slot or count change, conflict <= 1, accumulator_ctr still updates.
- Neither high: accumulator_ctr updates only.
- overflow and conflict clear only on reset.
- control_ctr wrap-around needs no special handling; only inequality is compared.
- With DEPTH = 1, full asserts after a single put.

Optional Feature:
- Macro: COLLECTOR_SUM_EN.
- Defined:
  - Adds output sum, width WIDTH+$clog2(DEPTH+1), equal to the unsigned sum of the data in all valid slots.
  - sum is registered and updated on the same edge as slot_valid/slot_data.
  - Reset value 0; returns to 0 after an op.
- Undefined: no sum port and no adder logic. Every other behaviour is identical.

Test Plan:
- Reset then three puts: ctr 1, 2, 3 with values 0x11, 0x22, 0x33 -> slot_data = {0x33, 0x22, 0x11}, slot_valid = 3'b111, count = 3, full = 1.
- Held instruction: put_en high, ctr = 5 held 4 cycles, value 0x7A -> only slot 0 written, count = 1.
- Fourth put at ctr 4 with value 0x44 while full -> slots unchanged, overflow = 1. Then op at ctr 5 -> op_fire one cycle, op_count = 3, slot_valid = 0, slot_data still {0x33, 0x22, 0x11}.
- put_en and op_en both high at ctr 9 after one put -> count stays 1, conflict = 1, accumulator_ctr = 9.
- Reset mid-fill after two puts -> all outputs 0. Next put at ctr 0 is accepted (first_pending) into slot 0.
- COLLECTOR_SUM_EN with DEPTH = 3, puts 0xFF, 0xFF, 0xFF -> sum = 10'h2FD; after op, sum = 0.
